// File: rtl/dac_switch_pkg.sv
// Shared constants for the two-channel DAC switch: setting addresses, gain limits,
// channel state encoding and the scale/round/saturate helper.
package dac_switch_pkg;

    localparam logic [6:0] FR_MRFM_DAC_K0 = 7'd40;
    localparam logic [6:0] FR_MRFM_DAC_K1 = 7'd41;
    localparam logic [4:0] GAIN_FULL      = 5'd16;

    typedef enum logic [1:0] {
        ST_MUTED,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } chan_state_t;

    // in*g, drop 4 fractional bits, round by +2, keep bits [15:2] with clamp
    function automatic logic signed [13:0] scale_sat(input logic signed [15:0] x,
                                                     input logic [4:0] g);
        logic signed [20:0] p;
        logic signed [16:0] s;
        logic signed [17:0] r;
        p = x * $signed({1'b0, g});
        s = p[20:4];
        r = {s[16], s} + 18'sd2;
        if (r > 18'sd32767)
            return 14'sh1FFF;
        else if (r < -18'sd32768)
            return 14'sh2000;
        else
            return r[15:2];
    endfunction

endpackage

// File: rtl/dac_switch_if.sv
// Setting bus, composite sample input and the two DAC sample outputs.
interface dac_switch_if;
    logic [6:0]         serial_addr;
    logic [31:0]        serial_data;
    logic               serial_strobe;
    logic signed [15:0] in;
    logic               in_strobe;
    logic signed [13:0] out0;
    logic signed [13:0] out1;
    logic               out_strobe;

    modport master (
        output serial_addr, serial_data, serial_strobe, in, in_strobe,
        input  out0, out1, out_strobe
    );

    modport slave (
        input  serial_addr, serial_data, serial_strobe, in, in_strobe,
        output out0, out1, out_strobe
    );
endinterface

// File: rtl/dac_fade_chan.sv
// One DAC channel: gain FSM plus registered scale/round/saturate output.
// MRFM_DAC_FADE_EN selects the 1-step-per-strobe fade; otherwise gain snaps to 0/16.
module dac_fade_chan
    import dac_switch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_strobe,
    input  logic signed [15:0] sample,
    output logic signed [13:0] out
);
    chan_state_t        state_reg, state_next;
    logic [4:0]         gain_reg, gain_next;
    logic signed [13:0] out_reg;

    // Sample is scaled with the gain held before this strobe's update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_MUTED;
            gain_reg  <= 5'd0;
            out_reg   <= 14'sd0;
        end else begin
            state_reg <= state_next;
            gain_reg  <= gain_next;
            if (in_strobe)
                out_reg <= scale_sat(sample, gain_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        if (in_strobe) begin
`ifdef MRFM_DAC_FADE_EN
            unique case (state_reg)
                ST_MUTED: begin
                    if (enable) begin
                        state_next = ST_RAMP_UP;
                        gain_next  = 5'd1;
                    end
                end
                // A reversed enable mid-ramp turns around from the current gain.
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (enable) begin
                        gain_next  = gain_reg + 5'd1;
                        state_next = (gain_reg == GAIN_FULL - 5'd1) ? ST_ON : ST_RAMP_UP;
                    end else begin
                        gain_next  = gain_reg - 5'd1;
                        state_next = (gain_reg == 5'd1) ? ST_MUTED : ST_RAMP_DOWN;
                    end
                end
                ST_ON: begin
                    if (!enable) begin
                        state_next = ST_RAMP_DOWN;
                        gain_next  = GAIN_FULL - 5'd1;
                    end
                end
                default: begin
                    state_next = ST_MUTED;
                    gain_next  = 5'd0;
                end
            endcase
`else
            state_next = enable ? ST_ON : ST_MUTED;
            gain_next  = enable ? GAIN_FULL : 5'd0;
`endif
        end
    end

    assign out = out_reg;
endmodule

// File: rtl/setting_reg.sv
// Addressed setting register: captures the bus data when the strobe hits its address.
module setting_reg #(
    parameter logic [6:0]       ADDR     = 7'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [31:0]      data,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] out_reg;

    always_ff @(posedge clock) begin
        if (reset)
            out_reg <= AT_RESET;
        else if (strobe && addr == ADDR)
            out_reg <= data[WIDTH-1:0];
    end

    assign out = out_reg;
endmodule

// File: rtl/dac_switch.sv
// Two-channel DAC switch: per-channel enable settings gate the composite sample.
// Fade ramps are built when MRFM_DAC_FADE_EN is defined.
module dac_switch
    import dac_switch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    dac_switch_if.slave  bus
);
    logic [31:0]        k_set   [2];
    logic signed [13:0] chan_out[2];
    logic               out_strobe_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            setting_reg #(
                .ADDR    ((gi == 0) ? FR_MRFM_DAC_K0 : FR_MRFM_DAC_K1),
                .WIDTH   (32),
                .AT_RESET(32'd0)
            ) u_k (
                .clock (clock),
                .reset (reset),
                .strobe(bus.serial_strobe),
                .addr  (bus.serial_addr),
                .data  (bus.serial_data),
                .out   (k_set[gi])
            );

            dac_fade_chan u_chan (
                .clock    (clock),
                .reset    (reset),
                .enable   (k_set[gi] != 32'd0),
                .in_strobe(bus.in_strobe),
                .sample   (bus.in),
                .out      (chan_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset)
            out_strobe_reg <= 1'b0;
        else
            out_strobe_reg <= bus.in_strobe;
    end

    assign bus.out0       = chan_out[0];
    assign bus.out1       = chan_out[1];
    assign bus.out_strobe = out_strobe_reg;
endmodule
